mem_write: RTL
==============

# mem_write

SPI-bus memory writer: the store-side counterpart of the CPU's SPI fetch path. It takes a 24-bit byte address and a 32-bit word from the core, then issues a single SPI WRITE (0x02) transaction to the external SPI SRAM/flash on the shared sclk/mosi/cs pins. It signals completion with a level handshake that mirrors the fetch unit's start/done convention.

## Interface
- No parameters; all constants come from the shared package.
- clk  input  1  system clock
- rst_n  input  1  reset, synchronous, active-low; clock clk
- target_address  input  24  byte address; sampled only at transaction start
- write_data  input  32  word to store; sampled only at transaction start
- start_write  input  1  level request; transaction launches when high in IDLE
- write_done  output  1  completion flag; high until start_write is seen low
- sclk  output  1  SPI clock, mode 0 (idle low)
- mosi  output  1  SPI data out, MSB first
- cs  output  1  SPI chip select, active-low

## Operation
- Reset values: cs=1, sclk=0, mosi=0, write_done=0, state=IDLE, bit counter=0.
- States: IDLE, SHIFT, END, DONE, plus WREN and GAP when MEM_WRITE_WREN_EN is defined.
- IDLE, start_write=1, write_done=0:
  - Load the 64-bit shift register with {CMD_WRITE 8'h02, target_address[23:0], write_data[7:0], write_data[15:8], write_data[23:16], write_data[31:24]}. Memory is little-endian, so the byte at the address is data[7:0].
  - Set cs<=0, mosi<=bit 63, sclk<=0, bit_cnt<=63, go to SHIFT.
- SHIFT:
  - If sclk=0: sclk<=1 (the slave samples here).
  - Otherwise: sclk<=0; then if bit_cnt=0 go to END, else shift left, set mosi to the next bit and decrement bit_cnt.
  - mosi changes only while sclk falls or is low.
- END: cs<=1, mosi<=0, write_done<=1, go to DONE.
- DONE: once start_write=0, write_done<=0 and go to IDLE.
  - If start_write is already low when DONE is entered, write_done is high for exactly one cycle.
- start_write dropping mid-transfer is ignored; the transfer always completes.
- Input changes after launch are ignored because inputs are latched.
- A new transaction needs start_write low for at least one cycle after write_done.

## Timing
- Let edge T be the edge at which IDLE sees start_write=1.
- cs falls at T. sclk rises on edges T+1, T+3, …, T+127 (64 rising edges) and falls on T+2, …, T+128.
- cs rises and write_done asserts at edge T+129. The SPI clock is clk/2.
- With MEM_WRITE_WREN_EN, the latency becomes T+148.
- Synchronous reset mid-transfer: at the next edge cs=1, sclk=0 and all other reset values apply. No further sclk edges; the partial write is abandoned.
- Reset has priority over every state transition.

## Configuration
- MEM_WRITE_WREN_EN defined:
  - IDLE launch first sends CMD_WREN 8'h06 (8 bits, 16 clk) in state WREN; at T+16 (final sclk fall) go to GAP.
  - GAP sets cs<=1 at edge T+17 and holds cs high for 2 cycles.
  - At edge T+19 load the WRITE frame exactly as from IDLE.
  - write_done at T+148. Required for SPI flash targets.
- Undefined: WREN/GAP states are absent; the WRITE frame is sent directly (SRAM targets).

## Structure
- Shared package mem_pkg:
  - Command constants CMD_READ 8'h03, CMD_WRITE 8'h02, CMD_WREN 8'h06.
  - mem_write state enum.
  - ADDR_W=24, DATA_W=32.
  - The fetch unit also uses this package.
- One sub-module is natural: spi_tx_shifter (parallel load, shift, sclk toggle, bit counter, last-bit flag), reused by the WREN and WRITE phases.
- mem_write owns only the phase FSM, cs and the handshake.

## Test plan
- Basic write: addr 0x000010, data 0x12345678, start held. mosi sampled on 64 rising edges reads 02 00 00 10 78 56 34 12. cs low T..T+128, write_done=1 at T+129.
- Handshake: hold start 10 cycles after done → done stays 1 and no sclk activity. Drop start → done=0 next edge. Re-raise with addr 0xFFFFFF, data 0xA5A5A5A5 → second frame 02 FF FF FF A5 A5 A5 A5.
- Input stability: change target_address to 0x123456 and write_data to 0 at T+20 → transmitted frame still carries the launch values.
- Reset mid-transfer: assert rst_n=0 at T+40 → next edge cs=1, sclk=0, mosi=0, done=0. No sclk edges until a new start.
- Early release: start_write pulsed high for one cycle → full 64-bit frame sent, done high exactly one cycle at T+129.
- WREN build (MEM_WRITE_WREN_EN): 0x06 framed by cs low T..T+16, cs high T+17..T+18, WRITE frame from T+19, done at T+148.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared SPI memory package: command opcodes, bus widths, the mem_write
// phase enum and the WRITE frame builder. The fetch unit imports this too.
// Optional build macro: MEM_WRITE_WREN_EN adds the WREN/GAP phases.
package mem_pkg;

    localparam int ADDR_W  = 24;
    localparam int DATA_W  = 32;
    localparam int FRAME_W = 8 + ADDR_W + DATA_W;

    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] CMD_WRITE = 8'h02;
    localparam logic [7:0] CMD_WREN  = 8'h06;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_END,
        ST_DONE
`ifdef MEM_WRITE_WREN_EN
        ,
        ST_WREN,
        ST_GAP
`endif
    } mem_write_state_t;

    // Memory is little-endian: the byte at the address is data[7:0], so the
    // data word goes out lowest byte first after the opcode and address.
    function automatic logic [FRAME_W-1:0] write_frame(
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] data
    );
        return {CMD_WRITE, addr, data[7:0], data[15:8], data[23:16], data[31:24]};
    endfunction

endpackage

// File: rtl/spi_tx_shifter.sv
// SPI mode-0 transmit shifter: parallel load, MSB-first shift, sclk toggle
// at clk/2, bit counter and a last-bit flag that fires on the final falling
// edge so the owning FSM can change phase on that same clock edge.
module spi_tx_shifter
    import mem_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [FRAME_W-1:0] load_data,
    input  logic [5:0]         load_cnt,
    input  logic               clear_mosi,
    output logic               sclk,
    output logic               mosi,
    output logic               last_bit
);

    logic [FRAME_W-1:0] shift_reg;
    logic [5:0]         bit_cnt_reg;
    logic               run_reg;
    logic               sclk_reg;
    logic               mosi_reg;

    assign sclk     = sclk_reg;
    assign mosi     = mosi_reg;
    assign last_bit = run_reg & sclk_reg & (bit_cnt_reg == 6'd0);

    // Load presents bit 63 immediately; afterwards mosi only moves on the
    // falling sclk edge so the slave always samples a settled bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shift_reg   <= '0;
            bit_cnt_reg <= 6'd0;
            run_reg     <= 1'b0;
            sclk_reg    <= 1'b0;
            mosi_reg    <= 1'b0;
        end else if (load) begin
            shift_reg   <= load_data;
            mosi_reg    <= load_data[FRAME_W-1];
            sclk_reg    <= 1'b0;
            bit_cnt_reg <= load_cnt;
            run_reg     <= 1'b1;
        end else if (run_reg) begin
            if (!sclk_reg) begin
                sclk_reg <= 1'b1;
            end else begin
                sclk_reg <= 1'b0;
                if (bit_cnt_reg == 6'd0) begin
                    run_reg <= 1'b0;
                end else begin
                    shift_reg   <= {shift_reg[FRAME_W-2:0], 1'b0};
                    mosi_reg    <= shift_reg[FRAME_W-2];
                    bit_cnt_reg <= bit_cnt_reg - 6'd1;
                end
            end
        end else if (clear_mosi) begin
            mosi_reg <= 1'b0;
        end
    end

endmodule

// File: rtl/mem_write.sv
// SPI memory writer: latches a 24-bit address and 32-bit word on a start
// request, sends one WRITE (0x02) frame, then holds write_done until the
// requester drops start_write.
// Build macro MEM_WRITE_WREN_EN: precede the WRITE frame with a WREN (0x06)
// command and a two-cycle cs-high gap, as needed by SPI flash parts.
module mem_write
    import mem_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] target_address,
    input  logic [DATA_W-1:0] write_data,
    input  logic              start_write,
    output logic              write_done,
    output logic              sclk,
    output logic              mosi,
    output logic              cs
);

    mem_write_state_t   state_reg;
    logic               cs_reg;
    logic               done_reg;
    logic               shift_load;
    logic [FRAME_W-1:0] shift_data;
    logic [5:0]         shift_cnt;
    logic               clear_mosi;
    logic               last_bit;
`ifdef MEM_WRITE_WREN_EN
    logic [1:0]         gap_cnt_reg;
    logic [FRAME_W-1:0] frame_reg;
`endif

    assign cs         = cs_reg;
    assign write_done = done_reg;
    assign clear_mosi = (state_reg == ST_END);

    // Choose what the shifter loads and when: the command/data frame at
    // launch, and in the WREN build the held WRITE frame after the gap.
    always_comb begin
        shift_load = 1'b0;
        shift_data = write_frame(target_address, write_data);
        shift_cnt  = 6'd63;
        case (state_reg)
            ST_IDLE: begin
                if (start_write && !done_reg) begin
                    shift_load = 1'b1;
`ifdef MEM_WRITE_WREN_EN
                    shift_data = {CMD_WREN, {(FRAME_W-8){1'b0}}};
                    shift_cnt  = 6'd7;
`endif
                end
            end
`ifdef MEM_WRITE_WREN_EN
            ST_GAP: begin
                shift_data = frame_reg;
                if (gap_cnt_reg == 2'd2) begin
                    shift_load = 1'b1;
                end
            end
`endif
            default: ;
        endcase
    end

    spi_tx_shifter u_shifter (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (shift_load),
        .load_data  (shift_data),
        .load_cnt   (shift_cnt),
        .clear_mosi (clear_mosi),
        .sclk       (sclk),
        .mosi       (mosi),
        .last_bit   (last_bit)
    );

    // Phase FSM: owns chip select and the level start/done handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            cs_reg      <= 1'b1;
            done_reg    <= 1'b0;
`ifdef MEM_WRITE_WREN_EN
            gap_cnt_reg <= 2'd0;
            frame_reg   <= '0;
`endif
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start_write && !done_reg) begin
                        cs_reg <= 1'b0;
`ifdef MEM_WRITE_WREN_EN
                        frame_reg <= write_frame(target_address, write_data);
                        state_reg <= ST_WREN;
`else
                        state_reg <= ST_SHIFT;
`endif
                    end
                end
`ifdef MEM_WRITE_WREN_EN
                ST_WREN: begin
                    if (last_bit) begin
                        state_reg <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_reg == 2'd2) begin
                        gap_cnt_reg <= 2'd0;
                        cs_reg      <= 1'b0;
                        state_reg   <= ST_SHIFT;
                    end else begin
                        gap_cnt_reg <= gap_cnt_reg + 2'd1;
                        cs_reg      <= 1'b1;
                    end
                end
`endif
                ST_SHIFT: begin
                    if (last_bit) begin
                        state_reg <= ST_END;
                    end
                end
                ST_END: begin
                    cs_reg    <= 1'b1;
                    done_reg  <= 1'b1;
                    state_reg <= ST_DONE;
                end
                ST_DONE: begin
                    if (!start_write) begin
                        done_reg  <= 1'b0;
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
